// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with an autonomous up/down scan sequencer.
// Accepted requests appear on y one clock later; scan mode walks the active line with a programmable dwell.
module decoder_nx2n_seq #(
    parameter int SEL_W = 4,
    parameter int DWELL = 1,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             scan,
    input  logic             dir,
    input  logic             stop,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic             shown;
    logic [SEL_W-1:0] nidx;
    logic             at_end;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign in_ready = en & (state == IDLE);

    always_comb begin
        nidx   = dir_q ? (idx - SEL_W'(1)) : (idx + SEL_W'(1));
        at_end = dir_q ? (idx == '0) : (idx == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dir_q   <= 1'b0;
            shown   <= 1'b0;
            idx     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (stop) begin
            // stop wins over pause and over a same-cycle accept; idx keeps its last value
            state   <= IDLE;
            shown   <= 1'b0;
            y       <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (!en) begin
            y       <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (state == IDLE) begin
            wrap <= 1'b0;
            if (in_valid) begin
                idx     <= sel;
                y       <= onehot(sel);
                y_valid <= 1'b1;
                shown   <= 1'b1;
                if (scan) begin
                    dir_q <= dir;
                    cnt   <= '0;
                    state <= SCAN;
                end
            end else if (shown) begin
                // re-present the held line after a pause
                y       <= onehot(idx);
                y_valid <= 1'b1;
            end
        end else begin
            y_valid <= 1'b1;
            if (cnt == DLAST) begin
                cnt  <= '0;
                idx  <= nidx;
                y    <= onehot(nidx);
                wrap <= at_end;
            end else begin
                cnt  <= cnt + CW'(1);
                y    <= onehot(idx);
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Directed bench for decoder_nx2n_seq: three instances with different SEL_W/DWELL share one stimulus bus.
module tb_decoder_nx2n_seq;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, scan, dir, stop;
    logic [3:0] sel;

    logic [15:0] y_a;  logic yv_a, wrap_a, rdy_a;  logic [3:0] idx_a;
    logic [7:0]  y_b;  logic yv_b, wrap_b, rdy_b;  logic [2:0] idx_b;
    logic [15:0] y_c;  logic yv_c, wrap_c, rdy_c;  logic [3:0] idx_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_nx2n_seq #(.SEL_W(4), .DWELL(2)) u_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_a),
        .sel(sel), .scan(scan), .dir(dir), .stop(stop),
        .y(y_a), .y_valid(yv_a), .idx(idx_a), .wrap(wrap_a)
    );

    decoder_nx2n_seq #(.SEL_W(3), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_b),
        .sel(sel[2:0]), .scan(scan), .dir(dir), .stop(stop),
        .y(y_b), .y_valid(yv_b), .idx(idx_b), .wrap(wrap_b)
    );

    decoder_nx2n_seq #(.SEL_W(4), .DWELL(3)) u_c (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_c),
        .sel(sel), .scan(scan), .dir(dir), .stop(stop),
        .y(y_c), .y_valid(yv_c), .idx(idx_c), .wrap(wrap_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] up_y   [7] = '{16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h0002};
    logic [7:0]  down_y [4] = '{8'h02, 8'h01, 8'h80, 8'h40};

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; scan = 1'b0; dir = 1'b0; stop = 1'b0; sel = '0;

        // reset state
        tick(); tick();
        check("rst_y", 32'(y_a), 32'h0);
        check("rst_yv", 32'(yv_a), 32'h0);
        check("rst_idx", 32'(idx_a), 32'h0);
        check("rst_wrap", 32'(wrap_a), 32'h0);
        check("rst_rdy", 32'(rdy_a), 32'h1);
        rst = 1'b0;

        // plain decode
        in_valid = 1'b1; sel = 4'd9;
        tick();
        check("dec9_y", 32'(y_a), 32'h0200);
        check("dec9_yv", 32'(yv_a), 32'h1);
        check("dec9_idx", 32'(idx_a), 32'd9);
        sel = 4'd0;
        tick();
        check("dec0_y", 32'(y_a), 32'h0001);
        in_valid = 1'b0; sel = 4'd5;
        tick();
        check("dec_hold_y", 32'(y_a), 32'h0001);
        check("dec_hold_rdy", 32'(rdy_a), 32'h1);

        // up-scan with wrap, DWELL=2
        do_reset();
        in_valid = 1'b1; scan = 1'b1; dir = 1'b0; sel = 4'd14;
        tick();
        in_valid = 1'b0; scan = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            check($sformatf("up_y%0d", i), 32'(y_a), 32'(up_y[i]));
            check($sformatf("up_wrap%0d", i), 32'(wrap_a), (i == 4) ? 32'h1 : 32'h0);
            check($sformatf("up_rdy%0d", i), 32'(rdy_a), 32'h0);
        end

        // down-scan, SEL_W=3, DWELL=1, then stop
        do_reset();
        in_valid = 1'b1; scan = 1'b1; dir = 1'b1; sel = 4'd1;
        tick();
        in_valid = 1'b0; scan = 1'b0; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check($sformatf("dn_y%0d", i), 32'(y_b), 32'(down_y[i]));
            check($sformatf("dn_wrap%0d", i), 32'(wrap_b), (i == 2) ? 32'h1 : 32'h0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("dn_stop_y", 32'(y_b), 32'h0);
        check("dn_stop_yv", 32'(yv_b), 32'h0);
        check("dn_stop_rdy", 32'(rdy_b), 32'h1);
        check("dn_stop_idx", 32'(idx_b), 32'd6);

        // pause for 4 cycles during the first dwell cycle of idx 5, DWELL=3
        do_reset();
        in_valid = 1'b1; scan = 1'b1; sel = 4'd5;
        tick();
        in_valid = 1'b0; scan = 1'b0;
        check("ps_start_y", 32'(y_c), 32'h0020);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ps_off_y%0d", i), 32'(y_c), 32'h0);
            check($sformatf("ps_off_yv%0d", i), 32'(yv_c), 32'h0);
            check($sformatf("ps_off_idx%0d", i), 32'(idx_c), 32'd5);
        end
        check("ps_off_rdy", 32'(rdy_c), 32'h0);
        en = 1'b1;
        tick();
        check("ps_res0_y", 32'(y_c), 32'h0020);
        check("ps_res0_yv", 32'(yv_c), 32'h1);
        tick();
        check("ps_res1_y", 32'(y_c), 32'h0020);
        tick();
        check("ps_step_y", 32'(y_c), 32'h0040);
        check("ps_step_idx", 32'(idx_c), 32'd6);

        // stop beats a same-cycle accept in IDLE
        do_reset();
        in_valid = 1'b1; sel = 4'd9;
        tick();
        stop = 1'b1; sel = 4'd3;
        tick();
        stop = 1'b0; in_valid = 1'b0;
        check("sim_y", 32'(y_a), 32'h0);
        check("sim_yv", 32'(yv_a), 32'h0);
        check("sim_idx", 32'(idx_a), 32'd9);

        // stop while paused during a scan
        in_valid = 1'b1; scan = 1'b1; sel = 4'd2;
        tick();
        in_valid = 1'b0; scan = 1'b0;
        en = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0; en = 1'b1;
        tick();
        check("stpen_y", 32'(y_a), 32'h0);
        check("stpen_yv", 32'(yv_a), 32'h0);
        check("stpen_rdy", 32'(rdy_a), 32'h1);
        tick();
        check("stpen_y2", 32'(y_a), 32'h0);

        // reset in the middle of a scan
        do_reset();
        in_valid = 1'b1; scan = 1'b1; sel = 4'd10;
        tick();
        in_valid = 1'b0; scan = 1'b0;
        tick(); tick();
        check("mid_idx", 32'(idx_a), 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_y", 32'(y_a), 32'h0);
        check("mid_rst_yv", 32'(yv_a), 32'h0);
        check("mid_rst_idx", 32'(idx_a), 32'h0);
        check("mid_rst_wrap", 32'(wrap_a), 32'h0);
        check("mid_rst_rdy", 32'(rdy_a), 32'h1);
        in_valid = 1'b1; sel = 4'd7;
        tick();
        in_valid = 1'b0;
        check("mid_dec_y", 32'(y_a), 32'h0080);
        check("mid_dec_yv", 32'(yv_a), 32'h1);
        tick();
        check("mid_dec_hold", 32'(y_a), 32'h0080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_nx2n_seq.md
# decoder_nx2n_seq

Registered, parametrised N-to-2^N one-hot decoder with a built-in scan sequencer. It is the successor to the fixed 4:16 combinational decoder. It adds:
- a generic select width;
- a valid/ready input handshake;
- a one-cycle registered output;
- an autonomous up/down scan mode that walks the active output line with a programmable dwell time.

It drives row/line-select and LED/matrix-strobe style loads from a single clock domain.

## Interface
Parameters:
- SEL_W, 4, select width; output width OUT_W = 2**SEL_W (derived, not overridable); legal 1..8
- DWELL, 1, clock cycles each scan position is held; legal >= 1

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable/pause
- in_valid  in  1  request present
- in_ready  out  1  request can be accepted (combinational)
- sel  in  SEL_W  select index (DECODE) or start index (SCAN)
- scan  in  1  request type, sampled on accept: 0 = DECODE, 1 = SCAN
- dir  in  1  scan direction, sampled on accept: 0 = up, 1 = down
- stop  in  1  terminate scan
- y  out  OUT_W  registered one-hot output, or all zeros
- y_valid  out  1  registered; high whenever y is one-hot
- idx  out  SEL_W  registered index of the active line
- wrap  out  1  registered one-cycle pulse on a scan wrap-around

## Operation
- States are IDLE and SCAN.
- in_ready = en & (state == IDLE).
- Accept occurs when in_valid & in_ready at a rising edge.
- **IDLE, accept with scan=0:** idx <= sel, y <= 1<<sel, y_valid <= 1. The state stays IDLE, and y holds until the next accept, stop or reset. Back-to-back accepts update the output every cycle.
- **IDLE, accept with scan=1:**
  - idx <= sel, y <= 1<<sel, y_valid <= 1.
  - dir is latched, the dwell counter is cleared, and the state goes to SCAN.
- **SCAN:**
  - The dwell counter increments each enabled cycle.
  - When it reaches DWELL-1 it clears, and idx steps by +1 (up) or -1 (down) modulo OUT_W.
  - y always equals 1<<idx.
- **Wrap-around:**
  - Up: idx goes OUT_W-1 -> 0.
  - Down: idx goes 0 -> OUT_W-1.
  - wrap pulses high for exactly the cycle in which the new idx is first presented. It is 0 at all other times.
- **stop:**
  - In SCAN: the state goes to IDLE; y <= 0, y_valid <= 0, idx holds its last value.
  - In IDLE: y <= 0, y_valid <= 0. stop takes priority over a same-cycle accept, and that accept does not occur; in_ready stays as defined.
- **en = 0 (pause):**
  - The state, idx and dwell counter freeze.
  - y <= 0, y_valid <= 0, and no accept occurs.
  - When en returns to 1, y <= 1<<idx and y_valid <= 1 on the next edge, but only if the block was showing a line before the pause (a valid flag is held internally). The dwell count resumes where it stopped.
- **stop while en = 0:** stop is still honoured; the state goes to IDLE and nothing resumes.
- **Width rules:**
  - idx arithmetic is SEL_W bits with natural wrap.
  - The dwell counter is max(1, clog2(DWELL)) bits.
  - With DWELL=1 the scan steps every cycle.

## Timing
- **Reset values:** y = 0, y_valid = 0, idx = 0, wrap = 0, state = IDLE, dwell counter = 0, internal valid flag = 0. in_ready therefore equals en after reset.
- Reset asserted mid-scan returns all of the above on the same edge.
- **Latency:** accept at edge k puts the decoded y at edge k. The output is visible in the cycle after the sampling cycle: exactly 1 cycle.
- **Scan cadence:** each position is held for DWELL enabled cycles. A full cycle is OUT_W*DWELL enabled cycles.
- **Pause cost:** a paused cycle adds no dwell progress.
- in_ready is combinational from en and state, with no combinational path from in_valid.

## Test plan
- **Reset/decode:** rst for 2 cycles, then in_valid=1, scan=0, sel=9, SEL_W=4 -> next cycle y=0x0200, y_valid=1, idx=9. Then sel=0 -> y=0x0001.
- **Up-scan wrap:** SEL_W=4, DWELL=2, accept scan=1, dir=0, sel=14 -> y = 0x4000, 0x4000, 0x8000, 0x8000, 0x0001. wrap=1 only in the first 0x0001 cycle; in_ready=0 throughout.
- **Down-scan:** SEL_W=3, DWELL=1, sel=1, dir=1 -> y = 0x02, 0x01, 0x80 (wrap=1), 0x40. Then stop=1 -> y=0, y_valid=0, in_ready=1, idx=6.
- **Pause:** mid-scan at idx=5 with the dwell count at 1 of 3, drop en for 4 cycles -> y=0, idx stays 5. After en rises, y=0x0020 for the remaining 2 cycles, then idx=6.
- **Simultaneous events:** in IDLE, assert stop, in_valid and sel=3 in the same cycle -> y=0, no accept. Also, stop together with en=0 during SCAN -> IDLE, and y stays 0 after en returns.
- **Reset mid-operation:** rst during SCAN at idx=11 -> next cycle all outputs are at reset values, state is IDLE, and a new decode accept works immediately.
